// File: rtl/rv_pkg.sv
// RV32I encoding constants and types shared by the instruction loader and decoder.
package rv_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 12;
    localparam int unsigned KIND_W  = 2;
    localparam int unsigned STATE_W = 2;

    // Major opcodes (identical to the decoder's view)
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    // funct3 / funct7 values for the supported subset
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [6:0] F7_ADD = 7'b0000000;

    typedef enum logic [KIND_W-1:0] {
        KIND_LW  = 2'b00,
        KIND_SW  = 2'b01,
        KIND_ADD = 2'b10,
        KIND_ILL = 2'b11
    } instr_kind_t;

    typedef enum logic [STATE_W-1:0] {
        LD_IDLE   = 2'd0,
        LD_ACCEPT = 2'd1,
        LD_WRITE  = 2'd2,
        LD_DONE   = 2'd3
    } load_state_t;

    // Symbolic instruction bundle handed to the encoder
    typedef struct packed {
        instr_kind_t         kind;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [IMM_W-1:0]    imm;
    } instr_fields_t;

    // Only the three supported kinds produce a word
    function automatic logic is_legal_kind(input instr_kind_t kind);
        return kind != KIND_ILL;
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I encoder: symbolic fields -> 32-bit instruction word.
module instr_encode
    import rv_pkg::*;
(
    input  instr_fields_t        i_fields,
    output logic [WORD_W-1:0]    o_word_c,
    output logic                 o_legal_c
);

    // Assemble the word for the selected kind; unused fields are ignored
    always_comb begin
        o_word_c  = '0;
        o_legal_c = is_legal_kind(i_fields.kind);
        case (i_fields.kind)
            KIND_LW: begin
                o_word_c = {i_fields.imm, i_fields.rs1, F3_W, i_fields.rd, OP_LOAD};
            end
            KIND_SW: begin
                o_word_c = {i_fields.imm[11:5], i_fields.rs2, i_fields.rs1, F3_W,
                            i_fields.imm[4:0], OP_STORE};
            end
            KIND_ADD: begin
                o_word_c = {F7_ADD, i_fields.rs2, i_fields.rs1, F3_ADD, i_fields.rd, OP_RTYPE};
            end
            default: begin
                o_word_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: encodes a stream of symbolic bundles into RV32I words
// and writes them sequentially into instruction memory.
module instr_loader
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [KIND_W-1:0]    in_kind,
    input  logic [REG_W-1:0]     in_rd,
    input  logic [REG_W-1:0]     in_rs1,
    input  logic [REG_W-1:0]     in_rs2,
    input  logic [IMM_W-1:0]     in_imm,
    input  logic                 in_last,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [WORD_W-1:0]    imem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [6:0]           count
);

    localparam int unsigned COUNT_W = 7;

    localparam logic [STATE_W-1:0] S_IDLE   = LD_IDLE;
    localparam logic [STATE_W-1:0] S_ACCEPT = LD_ACCEPT;
    localparam logic [STATE_W-1:0] S_WRITE  = LD_WRITE;
    localparam logic [STATE_W-1:0] S_DONE   = LD_DONE;

    localparam logic [ADDR_W-1:0]  ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0]  WORD_STEP  = ADDR_W'(4);
    localparam logic [COUNT_W-1:0] COUNT_LIM  = COUNT_W'(MAX_WORDS);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_next_state;

    logic [ADDR_W-1:0]   r_addr;
    logic [COUNT_W-1:0]  r_count;
    logic                r_err;
    logic                r_last;

    logic                r_in_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [WORD_W-1:0]   r_imem_wdata;

    instr_fields_t       w_fields;
    logic [WORD_W-1:0]   w_word_c;
    logic                w_legal_c;
    logic                w_xfer;
    logic [COUNT_W-1:0]  w_count_inc;
    logic                w_at_limit;
    logic [ADDR_W-1:0]   w_base_aligned;

    // Pack the incoming fields for the encoder
    always_comb begin
        w_fields.kind = instr_kind_t'(in_kind);
        w_fields.rd   = in_rd;
        w_fields.rs1  = in_rs1;
        w_fields.rs2  = in_rs2;
        w_fields.imm  = in_imm;
    end

    instr_encode u_encode (
        .i_fields  (w_fields),
        .o_word_c  (w_word_c),
        .o_legal_c (w_legal_c)
    );

    // Handshake, word-count limit and aligned start address
    always_comb begin
        w_xfer         = (r_state == S_ACCEPT) && in_valid && r_in_ready;
        w_count_inc    = r_count + COUNT_W'(1);
        w_at_limit     = (w_count_inc == COUNT_LIM);
        w_base_aligned = base_addr & ALIGN_MASK;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (w_xfer) begin
                    w_next_state = w_legal_c ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                w_next_state = (r_last || w_at_limit) ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Session datapath: address, count, sticky error and captured word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
            r_last       <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= w_base_aligned;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (w_xfer) begin
                        r_last       <= in_last;
                        r_imem_addr  <= r_addr;
                        r_imem_wdata <= w_word_c;
                        if (!w_legal_c) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + WORD_STEP;
                    r_count <= w_count_inc;
                    if (!r_last && w_at_limit) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_last <= r_last;
                end
            endcase
        end
    end

    // Registered status and strobe outputs, decoded from the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_imem_we  <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == S_ACCEPT);
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= (w_next_state == S_DONE);
            r_imem_we  <= (w_next_state == S_WRITE);
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign count      = r_count;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized sessions, reference model, scoreboard.
module tb_instr_loader;

    localparam int unsigned TB_MAX  = 4;
    localparam int          CYC_MAX = 300;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [11:0] in_imm;
    logic        in_last;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  count;

    instr_loader #(.ADDR_W(32), .MAX_WORDS(TB_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [6:0] cnt; logic err; } dn_t;

    wr_t exp_wr_q[$];
    dn_t exp_dn_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  b_kind [8];
    logic [4:0]  b_rd   [8];
    logic [4:0]  b_rs1  [8];
    logic [4:0]  b_rs2  [8];
    logic [11:0] b_imm  [8];
    logic        b_last [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference encoding built from the field positions of RV32I
    function automatic logic [31:0] ref_enc(input int i);
        logic [31:0] imm, rd, rs1, rs2;
        imm = 32'(b_imm[i]);
        rd  = 32'(b_rd[i]);
        rs1 = 32'(b_rs1[i]);
        rs2 = 32'(b_rs2[i]);
        case (b_kind[i])
            2'd0:    ref_enc = (imm << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
            2'd1:    ref_enc = ((imm >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
                               | ((imm & 32'h1f) << 7) | 32'h23;
            default: ref_enc = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
        endcase
    endfunction

    // Session model: list of writes, final count/err, and bundles consumed
    task automatic model_session(input logic [31:0] base, input int nb, output int acc);
        logic [31:0] a;
        int          n;
        logic        e;
        wr_t         w;
        dn_t         d;
        a   = base & 32'hFFFF_FFFC;
        n   = 0;
        e   = 1'b0;
        acc = 0;
        for (int i = 0; i < nb; i++) begin
            acc++;
            if (b_kind[i] == 2'd3) begin
                e = 1'b1;
                break;
            end
            w.addr = a;
            w.data = ref_enc(i);
            exp_wr_q.push_back(w);
            a = a + 32'd4;
            n++;
            if (b_last[i]) break;
            if (n == int'(TB_MAX)) begin
                e = 1'b1;
                break;
            end
        end
        d.cnt = 7'(n);
        d.err = e;
        exp_dn_q.push_back(d);
    endtask

    task automatic set_b(input int i, input logic [1:0] k, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [11:0] imm, input logic last);
        b_kind[i] = k;
        b_rd[i]   = rd;
        b_rs1[i]  = rs1;
        b_rs2[i]  = rs2;
        b_imm[i]  = imm;
        b_last[i] = last;
    endtask

    task automatic gen_random(output int nb);
        nb = $urandom_range(6, 1);
        for (int i = 0; i < nb; i++) begin
            set_b(i, ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2)),
                  5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
                  (i == nb - 1) || ($urandom_range(7) == 0));
        end
    endtask

    task automatic drive_bundle(input int i);
        in_kind = b_kind[i];
        in_rd   = b_rd[i];
        in_rs1  = b_rs1[i];
        in_rs2  = b_rs2[i];
        in_imm  = b_imm[i];
        in_last = b_last[i];
    endtask

    // Runs one session from posedge+1 to posedge+1; rst_at>0 resets during that write
    task automatic run_session(input logic [31:0] base, input int nb, input bit sv, input int rst_at);
        int   acc, idx, cyc, wcnt;
        bit   fin, first, prev_acc, hold, timedout, was_reset;
        idx = 0; cyc = 0; wcnt = 0;
        fin = 0; first = 1; prev_acc = 0; hold = 0; timedout = 0; was_reset = 0;
        model_session(base, nb, acc);
        start     = 1'b1;
        base_addr = base;
        if (sv) begin
            drive_bundle(0);
            in_valid = 1'b1;
            hold     = 1;
        end
        @(negedge clk);
        check("ready_in_idle", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = $urandom;
        while (!fin) begin
            if (imem_we) wcnt++;
            if (rst_at != 0 && wcnt == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_imem_we", 64'(imem_we), 64'd0);
                check("rst_busy",    64'(busy),    64'd0);
                check("rst_done",    64'(done),    64'd0);
                check("rst_count",   64'(count),   64'd0);
                check("rst_ready",   64'(in_ready), 64'd0);
                exp_wr_q.delete();
                exp_dn_q.delete();
                in_valid = 1'b0;
                @(negedge clk); #1;
                reset = 1'b0;
                @(posedge clk); #1;
                fin       = 1;
                was_reset = 1;
            end else begin
                if (!hold && idx < nb && $urandom_range(3) != 0) begin
                    drive_bundle(idx);
                    in_valid = 1'b1;
                    hold     = 1;
                end
                if (cyc % 5 == 3 && $urandom_range(1) == 1) begin
                    start     = 1'b1;
                    base_addr = $urandom;
                end
                @(negedge clk);
                if (first) begin
                    check("sess_busy",  64'(busy),  64'd1);
                    check("sess_err",   64'(err),   64'd0);
                    check("sess_count", 64'(count), 64'd0);
                    first = 0;
                end
                if (prev_acc) check("ready_after_xfer", 64'(in_ready), 64'd0);
                prev_acc = in_valid && in_ready;
                if (prev_acc) begin
                    idx++;
                    hold = 0;
                end
                if (done) fin = 1;
                @(posedge clk); #1;
                start = 1'b0;
                if (!hold) in_valid = 1'b0;
                cyc++;
                if (cyc > CYC_MAX) begin
                    timedout = 1;
                    fin      = 1;
                end
            end
        end
        in_valid = 1'b0;
        check("session_timeout", 64'(timedout), 64'd0);
        if (!was_reset) begin
            check("bundles_accepted", 64'(idx), 64'(acc));
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_done", 64'(done), 64'd0);
        end
    endtask

    // Scoreboard monitor: compares every write strobe and done pulse
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (!reset) begin
            if (imem_we) begin
                check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0) begin
                    w = exp_wr_q.pop_front();
                    check("wr_addr", 64'(imem_addr),  64'(w.addr));
                    check("wr_data", 64'(imem_wdata), 64'(w.data));
                end
            end
            if (done) begin
                check("done_expected", 64'(exp_dn_q.size() != 0), 64'd1);
                if (exp_dn_q.size() != 0) begin
                    d = exp_dn_q.pop_front();
                    check("done_count", 64'(count), 64'(d.cnt));
                    check("done_err",   64'(err),   64'(d.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_kind   = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        in_last   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_imem_we",  64'(imem_we),    64'd0);
        check("reset_addr",     64'(imem_addr),  64'd0);
        check("reset_wdata",    64'(imem_wdata), 64'd0);
        check("reset_busy",     64'(busy),       64'd0);
        check("reset_done",     64'(done),       64'd0);
        check("reset_err",      64'(err),        64'd0);
        check("reset_count",    64'(count),      64'd0);
        check("reset_ready",    64'(in_ready),   64'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Single lw with last
        set_b(0, 2'd0, 5'd5, 5'd2, 5'd0, 12'd8, 1'b1);
        run_session(32'h100, 1, 0, 0);

        // Three-bundle program, start presented together with in_valid
        set_b(0, 2'd0, 5'd5, 5'd2, 5'd0, 12'd8,  1'b0);
        set_b(1, 2'd1, 5'd0, 5'd2, 5'd6, 12'd12, 1'b0);
        set_b(2, 2'd2, 5'd7, 5'd5, 5'd6, 12'd0,  1'b1);
        run_session(32'h0, 3, 1, 0);

        // Illegal second bundle
        set_b(0, 2'd1, 5'd1, 5'd3, 5'd9, 12'hFA5, 1'b0);
        set_b(1, 2'd3, 5'd4, 5'd4, 5'd4, 12'h000, 1'b0);
        set_b(2, 2'd2, 5'd7, 5'd5, 5'd6, 12'h000, 1'b1);
        run_session(32'h200, 3, 0, 0);

        // Following session starts with err cleared
        set_b(0, 2'd0, 5'd5, 5'd2, 5'd0, 12'd8, 1'b1);
        run_session(32'h400, 1, 0, 0);

        // Overflow: five bundles, no last
        for (int i = 0; i < 5; i++) set_b(i, 2'd2, 5'(i), 5'(i + 1), 5'(i + 2), 12'd0, 1'b0);
        run_session(32'h300, 5, 1, 0);

        // Unaligned base near top of address space wraps
        for (int i = 0; i < 3; i++) set_b(i, 2'd0, 5'(i + 3), 5'd1, 5'd0, 12'(i * 4), i == 2);
        run_session(32'hFFFF_FFFA, 3, 0, 0);

        // Reset during the second write, then reload from a new base
        for (int i = 0; i < 3; i++) set_b(i, 2'd1, 5'd0, 5'd2, 5'(i + 8), 12'(i * 40), 1'b0);
        run_session(32'h500, 3, 1, 2);
        set_b(0, 2'd2, 5'd9, 5'd10, 5'd11, 12'd0, 1'b0);
        set_b(1, 2'd0, 5'd12, 5'd13, 5'd0, 12'h800, 1'b1);
        run_session(32'h600, 2, 0, 0);

        // Randomized sessions
        for (int s = 0; s < 30; s++) begin
            gen_random(nb);
            run_session($urandom, nb, 1'($urandom_range(1)), 0);
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        check("wr_queue_empty",   64'(exp_wr_q.size()), 64'd0);
        check("done_queue_empty", 64'(exp_dn_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
